// File: rtl/io_intr_pkg.sv
// Shared types and constants for the IO interrupt arbiter.
// int_vec layout: {class, index}, where the class bit is the MSB and 1 means fast.
package io_intr_pkg;

  typedef enum logic [2:0] {
    StIdle,
    StFreq,
    StNreq,
    StFsrv,
    StNsrv,
    StGap
  } state_e;

  localparam logic CLASS_FAST = 1'b1;
  localparam logic CLASS_NORM = 1'b0;

endpackage

// File: rtl/io_rr_pick.sv
// Combinational round-robin picker: the first set request at or after ptr_i,
// wrapping from NDEV-1 back to 0.
module io_rr_pick
  import io_intr_pkg::*;
#(
  parameter int unsigned NDEV  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic [NDEV-1:0]  req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic             valid_o,
  output logic [IDX_W-1:0] idx_o
);

  int unsigned       cand;
  logic [IDX_W-1:0]  cand_idx;

  always_comb begin
    valid_o  = 1'b0;
    idx_o    = '0;
    cand     = 0;
    cand_idx = '0;
    for (int unsigned i = 0; i < NDEV; i++) begin
      cand     = (32'(ptr_i) + i) % NDEV;
      cand_idx = IDX_W'(cand);
      if (!valid_o && req_i[cand_idx]) begin
        valid_o = 1'b1;
        idx_o   = cand_idx;
      end
    end
  end

endmodule

// File: rtl/io_intr_arbiter.sv
// Interrupt arbiter/sequencer between the CPU and NDEV IO modules.
// Define INTR_NEST_EN to let a fast request preempt a normal service routine (depth 1).
module io_intr_arbiter
  import io_intr_pkg::*;
#(
  parameter int unsigned NDEV  = 3,
  parameter int unsigned IDX_W = 2
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic [NDEV-1:0]  fintr_req,
  input  logic [NDEV-1:0]  intr_req,
  output logic             cpu_fintr,
  output logic             cpu_intr,
  input  logic             cpu_inta,
  input  logic             cpu_iret,
  output logic [IDX_W:0]   int_vec,
  output logic [NDEV-1:0]  int_ack,
  output logic [NDEV-1:0]  io_enable
);

  state_e           state_q;
  logic [IDX_W-1:0] ptr_f_q, ptr_n_q, idx_q;
  logic             f_valid, n_valid;
  logic [IDX_W-1:0] f_idx, n_idx;
`ifdef INTR_NEST_EN
  logic [IDX_W-1:0] saved_idx_q;
  logic             saved_v_q;
`endif

  function automatic logic [NDEV-1:0] onehot(input logic [IDX_W-1:0] i);
    return {{(NDEV-1){1'b0}}, 1'b1} << i;
  endfunction

  function automatic logic [IDX_W-1:0] next_ptr(input logic [IDX_W-1:0] k);
    return (32'(k) == NDEV - 1) ? '0 : k + 1'b1;
  endfunction

  io_rr_pick #(.NDEV(NDEV), .IDX_W(IDX_W)) u_pick_fast (
    .req_i   (fintr_req),
    .ptr_i   (ptr_f_q),
    .valid_o (f_valid),
    .idx_o   (f_idx)
  );

  io_rr_pick #(.NDEV(NDEV), .IDX_W(IDX_W)) u_pick_norm (
    .req_i   (intr_req),
    .ptr_i   (ptr_n_q),
    .valid_o (n_valid),
    .idx_o   (n_idx)
  );

  always_ff @(posedge Clk) begin
    if (Reset) begin
      state_q     <= StIdle;
      ptr_f_q     <= '0;
      ptr_n_q     <= '0;
      idx_q       <= '0;
      cpu_fintr   <= 1'b0;
      cpu_intr    <= 1'b0;
      int_vec     <= '0;
      int_ack     <= '0;
      io_enable   <= '0;
`ifdef INTR_NEST_EN
      saved_idx_q <= '0;
      saved_v_q   <= 1'b0;
`endif
    end else begin
      int_ack <= '0;
      unique case (state_q)
        StIdle: begin
          if (f_valid) begin
            idx_q     <= f_idx;
            int_vec   <= {CLASS_FAST, f_idx};
            cpu_fintr <= 1'b1;
            ptr_f_q   <= next_ptr(f_idx);
            state_q   <= StFreq;
          end else if (n_valid) begin
            idx_q    <= n_idx;
            int_vec  <= {CLASS_NORM, n_idx};
            cpu_intr <= 1'b1;
            ptr_n_q  <= next_ptr(n_idx);
            state_q  <= StNreq;
          end
        end
        StFreq: begin
          if (cpu_inta) begin
            int_ack   <= onehot(idx_q);
            io_enable <= onehot(idx_q);
            cpu_fintr <= 1'b0;
            state_q   <= StFsrv;
          end
        end
        StNreq: begin
          if (cpu_inta) begin
            int_ack   <= onehot(idx_q);
            io_enable <= onehot(idx_q);
            cpu_intr  <= 1'b0;
            state_q   <= StNsrv;
          end
        end
        StFsrv: begin
          if (cpu_iret) begin
`ifdef INTR_NEST_EN
            if (saved_v_q) begin
              // Resume the preempted normal routine directly; it was acked already.
              idx_q     <= saved_idx_q;
              int_vec   <= {CLASS_NORM, saved_idx_q};
              io_enable <= onehot(saved_idx_q);
              saved_v_q <= 1'b0;
              state_q   <= StNsrv;
            end else begin
              io_enable <= '0;
              state_q   <= StGap;
            end
`else
            io_enable <= '0;
            state_q   <= StGap;
`endif
          end
        end
        StNsrv: begin
          if (cpu_iret) begin
            io_enable <= '0;
            state_q   <= StGap;
          end
`ifdef INTR_NEST_EN
          else if (f_valid) begin
            // The normal device keeps its Enable until the fast ack cycle.
            saved_idx_q <= idx_q;
            saved_v_q   <= 1'b1;
            idx_q       <= f_idx;
            int_vec     <= {CLASS_FAST, f_idx};
            cpu_fintr   <= 1'b1;
            ptr_f_q     <= next_ptr(f_idx);
            state_q     <= StFreq;
          end
`endif
        end
        StGap:   state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_io_intr_arbiter.sv
// Self-checking bench for io_intr_arbiter: per-cycle vector table with a scoreboard queue,
// plus a service-sequence scenario checked by an int_ack monitor.
module tb_io_intr_arbiter;
  import io_intr_pkg::*;

  logic       Clk;
  logic       Reset;
  logic [2:0] fintr_req, intr_req;
  logic       cpu_fintr, cpu_intr, cpu_inta, cpu_iret;
  logic [2:0] int_vec, int_ack, io_enable;

  int checks = 0;
  int errors = 0;

  io_intr_arbiter #(.NDEV(3), .IDX_W(2)) dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .fintr_req (fintr_req),
    .intr_req  (intr_req),
    .cpu_fintr (cpu_fintr),
    .cpu_intr  (cpu_intr),
    .cpu_inta  (cpu_inta),
    .cpu_iret  (cpu_iret),
    .int_vec   (int_vec),
    .int_ack   (int_ack),
    .io_enable (io_enable)
  );

  initial Clk = 1'b0;
  always #5 Clk = ~Clk;

  typedef struct packed {
    logic       rst;
    logic [2:0] f, n;
    logic       a, r;
    logic       ef, ei;
    logic [2:0] vec, ack, en;
  } vec_t;

  vec_t        tbl[$];
  logic [10:0] exp_q[$];

  function automatic vec_t v(input logic rst, input logic [2:0] f, input logic [2:0] n,
                             input logic a, input logic r, input logic ef, input logic ei,
                             input logic [2:0] vec, input logic [2:0] ack,
                             input logic [2:0] en);
    vec_t t;
    t.rst = rst; t.f = f; t.n = n; t.a = a; t.r = r;
    t.ef = ef; t.ei = ei; t.vec = vec; t.ack = ack; t.en = en;
    return t;
  endfunction

  task automatic run_table();
    logic [10:0] want, got;
    for (int i = 0; i < tbl.size(); i++) begin
      Reset     = tbl[i].rst;
      fintr_req = tbl[i].f;
      intr_req  = tbl[i].n;
      cpu_inta  = tbl[i].a;
      cpu_iret  = tbl[i].r;
      exp_q.push_back({tbl[i].ef, tbl[i].ei, tbl[i].vec, tbl[i].ack, tbl[i].en});
      @(posedge Clk);
      #1;
      want = exp_q.pop_front();
      got  = {cpu_fintr, cpu_intr, int_vec, int_ack, io_enable};
      checks++;
      if (got !== want) begin
        errors++;
        $display("FAIL vec[%0d] {fintr,intr,vec,ack,en}: got %b_%b_%b_%b_%b want %b_%b_%b_%b_%b",
                 i, got[10], got[9], got[8:6], got[5:3], got[2:0],
                 want[10], want[9], want[8:6], want[5:3], want[2:0]);
      end
    end
    tbl.delete();
  endtask

  // Scoreboard for the service sequence: expected {class,idx} per int_ack pulse.
  logic [2:0] ack_exp_q[$];
  logic       mon_en = 1'b0;
  int         ack_cnt = 0;

  always @(negedge Clk) begin
    if (mon_en && int_ack != 3'b000) begin
      logic [2:0] e;
      ack_cnt++;
      checks++;
      if (ack_exp_q.size() == 0) begin
        errors++;
        $display("FAIL ack_extra: got vec=%b ack=%b want no pulse", int_vec, int_ack);
      end else begin
        e = ack_exp_q.pop_front();
        if (int_vec !== e || int_ack !== (3'b001 << e[1:0])) begin
          errors++;
          $display("FAIL ack_order: got vec=%b ack=%b want vec=%b ack=%b",
                   int_vec, int_ack, e, 3'b001 << e[1:0]);
        end
      end
    end
  end

  task automatic service(input logic fast, input int idx);
    bit seen = 0;
    if (fast) fintr_req[idx] = 1'b1;
    else      intr_req[idx]  = 1'b1;
    ack_exp_q.push_back({fast, 2'(idx)});
    for (int c = 0; c < 10 && !seen; c++) begin
      @(posedge Clk);
      #1;
      seen = fast ? (cpu_fintr == 1'b1) : (cpu_intr == 1'b1);
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL svc_req_timeout: got no cpu request want %s request",
               fast ? "fast" : "normal");
    end
    cpu_inta = 1'b1;
    @(posedge Clk); #1;
    cpu_inta  = 1'b0;
    fintr_req = 3'b000;
    intr_req  = 3'b000;
    @(posedge Clk); #1;
    cpu_iret = 1'b1;
    @(posedge Clk); #1;
    cpu_iret = 1'b0;
    @(posedge Clk); #1;
  endtask

  initial begin
    Reset = 1'b1; fintr_req = '0; intr_req = '0; cpu_inta = 1'b0; cpu_iret = 1'b0;

    // Basic normal service on IO0.
    tbl.push_back(v(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b001, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    // Fast beats normal in the same cycle; normal follows after iret and gap.
    tbl.push_back(v(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b100, 3'b011, 1'b0, 1'b0, 1'b1, 1'b0, 3'b110, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b011, 1'b1, 1'b0, 1'b0, 1'b0, 3'b110, 3'b100, 3'b100));
    tbl.push_back(v(1'b0, 3'b000, 3'b011, 1'b0, 1'b1, 1'b0, 1'b0, 3'b110, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 1'b0, 3'b110, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b011, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    // Round robin 0,1,2,0 with iret ignored in NREQ, latched winner, inta beating iret.
    tbl.push_back(v(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b001, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b1, 1'b1, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b001, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 3'b001, 3'b010, 3'b010));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b001, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b010, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 3'b010, 3'b100, 3'b100));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b1, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b0, 3'b010, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b111, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    // Reset in FSRV clears outputs and the fast pointer (next pick from 3'b110 is idx 1).
    tbl.push_back(v(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b110, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b110, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 3'b010, 3'b010));
    tbl.push_back(v(1'b1, 3'b110, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b110, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 3'b010, 3'b010));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 3'b000, 3'b000));
    // Fast request during a normal service on IO0.
    tbl.push_back(v(1'b1, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b001, 1'b0, 1'b0, 1'b0, 1'b1, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b001, 3'b001));
`ifdef INTR_NEST_EN
    tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 3'b010, 3'b010));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
`else
    tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b001));
    tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b000, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b010, 3'b000, 1'b0, 1'b0, 1'b1, 1'b0, 3'b101, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b1, 1'b0, 1'b0, 1'b0, 3'b101, 3'b010, 3'b010));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b1, 1'b0, 1'b0, 3'b101, 3'b000, 3'b000));
    tbl.push_back(v(1'b0, 3'b000, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 3'b101, 3'b000, 3'b000));
`endif
    run_table();

    // IO2 model: eight normal services, two fast, two normal; exactly 12 acks in that order.
    Reset = 1'b1;
    @(posedge Clk); #1;
    Reset  = 1'b0;
    mon_en = 1'b1;
    for (int k = 0; k < 8; k++) service(CLASS_NORM, 2);
    for (int k = 0; k < 2; k++) service(CLASS_FAST, 2);
    for (int k = 0; k < 2; k++) service(CLASS_NORM, 2);
    repeat (3) @(posedge Clk);
    #1;
    mon_en = 1'b0;
    checks++;
    if (ack_cnt != 12 || ack_exp_q.size() != 0) begin
      errors++;
      $display("FAIL ack_count: got %0d pulses (%0d unmatched) want 12 (0 unmatched)",
               ack_cnt, ack_exp_q.size());
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
